// File: rtl/twitchcore_pkg.sv
// Shared twitchcore definitions: console/tohost address defaults, UART TX states
// and the bit positions of the console status word.
package twitchcore_pkg;

    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;
    localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h1000_0004;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERFLOW = 2;

endpackage

// File: rtl/uart_console_byte_fifo.sv
// Synchronous circular-buffer FIFO. The extra pointer MSB tells full from empty.
// The caller only pushes when there is room (or a pop happens in the same cycle).
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage has no reset: a reset only moves the pointers, so old contents become unreachable.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/uart_console.sv
// Console/test-result peripheral: stores to CONSOLE_ADDR go out 8N1 on tx,
// and the first store to TOHOST_ADDR latches the done/pass verdict.
module uart_console
    import twitchcore_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic        done,
    output logic        pass
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic      w_conWr;
    logic      w_push;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    logic      w_baudDone;
    logic [7:0] w_dout;

    tx_state_t     r_state;
    tx_state_t     w_stateNext;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baudNext;
    logic [2:0]    r_bitCnt;
    logic [2:0]    w_bitNext;
    logic [7:0]    r_shift;
    logic [7:0]    w_shiftNext;
    logic          r_tx;
    logic          w_txNext;

    // A full FIFO still accepts a byte when the transmitter pops in the same cycle.
    assign w_conWr = wr_en && (wr_addr == CONSOLE_ADDR);
    assign w_push  = w_conWr && (!w_full || w_pop);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_din    (wr_data[7:0]),
        .o_dout   (w_dout),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_baud   <= w_baudNext;
            r_bitCnt <= w_bitNext;
            r_shift  <= w_shiftNext;
            r_tx     <= w_txNext;
        end
    end

    assign w_baudDone = (r_baud == BAUD_LAST);

    // tx is registered, so each transition loads the level of the bit that starts next.
    always_comb begin
        w_stateNext = r_state;
        w_baudNext  = r_baud + 1'b1;
        w_bitNext   = r_bitCnt;
        w_shiftNext = r_shift;
        w_txNext    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_baudNext = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_dout;
                    w_txNext    = 1'b0;
                    w_stateNext = START;
                end
            end
            START: begin
                if (w_baudDone) begin
                    w_baudNext  = '0;
                    w_bitNext   = '0;
                    w_txNext    = r_shift[0];
                    w_stateNext = DATA;
                end
            end
            DATA: begin
                if (w_baudDone) begin
                    w_baudNext = '0;
                    if (r_bitCnt == 3'd7) begin
                        w_txNext    = 1'b1;
                        w_stateNext = STOP;
                    end else begin
                        w_bitNext   = r_bitCnt + 1'b1;
                        w_shiftNext = r_shift >> 1;
                        w_txNext    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_baudDone) begin
                    w_baudNext = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_dout;
                        w_txNext    = 1'b0;
                        w_stateNext = START;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_baudNext  = '0;
                w_txNext    = 1'b1;
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            if (w_conWr && w_full && !w_pop) overflow <= 1'b1;
            if (wr_en && (wr_addr == TOHOST_ADDR) && !done) begin
                done <= 1'b1;
                pass <= (wr_data == 32'd1);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr == CONSOLE_ADDR) begin
            rd_data[STAT_EMPTY]    = w_empty;
            rd_data[STAT_FULL]     = w_full;
            rd_data[STAT_OVERFLOW] = overflow;
        end
    end

    assign tx   = r_tx;
    assign busy = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_uart_console.sv
// Self-checking bench for uart_console: every cycle is compared against a frame-timeline
// model (byte queue plus frame start times) alongside directed latency and verdict checks.
module tb_uart_console;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] CON   = 32'h1000_0000;
    localparam logic [31:0] TOH   = 32'h1000_0004;
    localparam logic [31:0] OTHER = 32'h1000_0008;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    logic        wr_en   = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_addr = CON;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic        done;
    logic        pass;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes waiting, and the byte on the line with the cycle its start bit began.
    logic [7:0] mQ[$];
    logic [7:0] curByte;
    int         mc;
    int         frameStart;
    bit         inFrame;
    bit         mOvf;
    bit         mDone;
    bit         mPass;

    uart_console #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CONSOLE_ADDR (CON),
        .TOHOST_ADDR  (TOH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .done     (done),
        .pass     (pass)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        inFrame    = 1'b0;
        frameStart = 0;
        curByte    = '0;
        mOvf       = 1'b0;
        mDone      = 1'b0;
        mPass      = 1'b0;
        mc         = 0;
    endtask

    // One clock of the model: a frame may start when the line is free or a frame just ended.
    task automatic modelStep();
        bit lastCycle;
        bit pop;
        lastCycle = inFrame && (mc == frameStart + FRAME - 1);
        pop       = (mQ.size() > 0) && (!inFrame || lastCycle);
        if (pop) begin
            curByte    = mQ.pop_front();
            frameStart = mc + 1;
            inFrame    = 1'b1;
        end else if (lastCycle) begin
            inFrame = 1'b0;
        end
        if (wr_en && wr_addr == CON) begin
            if (mQ.size() < DEPTH) mQ.push_back(wr_data[7:0]);
            else mOvf = 1'b1;
        end
        if (wr_en && wr_addr == TOH && !mDone) begin
            mDone = 1'b1;
            mPass = (wr_data == 32'd1);
        end
        mc++;
    endtask

    function automatic logic expTx();
        int bitIdx;
        if (!inFrame) return 1'b1;
        bitIdx = (mc - frameStart) / CPB;
        if (bitIdx == 0) return 1'b0;
        if (bitIdx >= 9) return 1'b1;
        return curByte[bitIdx - 1];
    endfunction

    function automatic logic [31:0] expRd();
        logic [31:0] v;
        v = '0;
        if (rd_addr == CON) begin
            v[0] = (mQ.size() == 0);
            v[1] = (mQ.size() == DEPTH);
            v[2] = mOvf;
        end
        return v;
    endfunction

    task automatic checkCycle();
        checkOutput("tx", {31'b0, tx}, {31'b0, expTx()});
        checkOutput("busy", {31'b0, busy}, {31'b0, (mQ.size() > 0) || inFrame});
        checkOutput("overflow", {31'b0, overflow}, {31'b0, mOvf});
        checkOutput("done", {31'b0, done}, {31'b0, mDone});
        checkOutput("pass", {31'b0, pass}, {31'b0, mPass});
        checkOutput("rd_data", rd_data, expRd());
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkCycle();
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] addr, input logic [31:0] data);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        rd_addr = ($urandom_range(0, 7) == 0) ? TOH : CON;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom(), $urandom());
    endtask

    // Entered at a negedge; optionally checks that reset takes effect before any clock edge.
    task automatic doReset(input bit checkImmediate);
        wr_en   = 1'b0;
        rd_addr = CON;
        resetn  = 1'b0;
        #1;
        if (checkImmediate) begin
            checkOutput("async_reset_tx", {31'b0, tx}, 32'd1);
            checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
            checkOutput("async_reset_status", rd_data, 32'd1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        modelReset();
        #1;
        checkCycle();
    endtask

    task automatic waitIdle(input int budget, output int fallCycle);
        int guard;
        guard = 0;
        while (busy && guard < budget) begin
            idle(1);
            guard++;
        end
        if (guard >= budget) checkOutput("idle_timeout", {31'b0, busy}, 32'd0);
        fallCycle = mc;
    endtask

    initial begin
        int n;
        int fall;
        int r;

        $display("[TB] uart_console bench, CLKS_PER_BIT=%0d FIFO_DEPTH=%0d", CPB, DEPTH);
        modelReset();
        @(negedge clk);
        doReset(1'b0);
        checkOutput("reset_status", rd_data, 32'd1);
        checkOutput("reset_tx", {31'b0, tx}, 32'd1);

        // Single byte: start bit two cycles after the push, busy drops 42 cycles after it.
        n = mc;
        applyStimulus(1'b1, CON, 32'h0000_004F);
        waitIdle(200, fall);
        checkOutput("single_busy_fall", fall, n + 42);
        idle(5);

        // "OK\n" in consecutive cycles: three contiguous frames.
        n = mc;
        applyStimulus(1'b1, CON, 32'h4F);
        applyStimulus(1'b1, CON, 32'h4B);
        applyStimulus(1'b1, CON, 32'h0A);
        waitIdle(400, fall);
        checkOutput("ok_busy_fall", fall, n + 2 + 3 * FRAME);
        idle(3);

        // Ten pushes: one in flight, eight queued, the tenth dropped.
        n = mc;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, CON, $urandom());
        rd_addr = CON;
        #1;
        checkOutput("ovf_flag", {31'b0, overflow}, 32'd1);
        checkOutput("ovf_status", rd_data, 32'h6);
        waitIdle(1000, fall);
        checkOutput("ovf_busy_fall", fall, n + 2 + 9 * FRAME);

        // Full FIFO with a push landing exactly on the end-of-stop pop.
        doReset(1'b0);
        n = mc;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, CON, $urandom());
        while (mc < n + FRAME + 1) idle(1);
        applyStimulus(1'b1, CON, 32'hA5);
        checkOutput("fullpop_no_ovf", {31'b0, overflow}, 32'd0);
        waitIdle(1000, fall);
        checkOutput("fullpop_busy_fall", fall, n + 2 + 10 * FRAME);
        checkOutput("fullpop_no_ovf_end", {31'b0, overflow}, 32'd0);

        // Random console traffic mixed with writes that must have no effect.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) applyStimulus(1'b1, CON, $urandom());
            else if (r == 3) applyStimulus(1'b1, OTHER, $urandom());
            else applyStimulus(1'b0, CON, $urandom());
        end
        waitIdle(1000, fall);

        // Verdicts: only the first write counts; any value other than 1 means fail.
        doReset(1'b0);
        applyStimulus(1'b1, TOH, 32'd1);
        checkOutput("verdict_done", {31'b0, done}, 32'd1);
        checkOutput("verdict_pass", {31'b0, pass}, 32'd1);
        idle(2);
        applyStimulus(1'b1, TOH, 32'd3);
        checkOutput("verdict_sticky_pass", {31'b0, pass}, 32'd1);
        doReset(1'b0);
        checkOutput("verdict_cleared", {31'b0, done}, 32'd0);
        applyStimulus(1'b1, TOH, 32'd3);
        checkOutput("verdict3_done", {31'b0, done}, 32'd1);
        checkOutput("verdict3_pass", {31'b0, pass}, 32'd0);
        doReset(1'b0);
        applyStimulus(1'b1, TOH, 32'd0);
        checkOutput("verdict0_done", {31'b0, done}, 32'd1);
        checkOutput("verdict0_pass", {31'b0, pass}, 32'd0);

        // Reset in the middle of the data bits, with more bytes still queued.
        doReset(1'b0);
        applyStimulus(1'b1, CON, 32'h00);
        applyStimulus(1'b1, CON, 32'h55);
        applyStimulus(1'b1, CON, 32'h33);
        idle(2 + CPB + 3 * CPB);
        doReset(1'b1);
        idle(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_console.md
Name: uart_console

Overview:
- Memory-mapped console and test-result peripheral on the twitchcore data bus, directly downstream of the core's store path.
- Firmware stores bytes to CONSOLE_ADDR. Bytes are queued in a FIFO and serialized 8N1 on a UART tx line.
- A store to TOHOST_ADDR latches the test verdict as done/pass flags, so the bench can end simulation without peeking at core registers.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (>=2).
- FIFO_DEPTH, 8, byte entries; power of two, >=2.
- CONSOLE_ADDR, 32'h1000_0000, data write / status read address.
- TOHOST_ADDR, 32'h1000_0004, verdict write address.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  store strobe, one cycle per store.
- wr_addr  in  32  store address.
- wr_data  in  32  store data.
- rd_addr  in  32  load address.
- rd_data  out  32  load data (combinational).
- tx  out  1  UART serial output, registered.
- busy  out  1  FIFO non-empty or frame in flight.
- overflow  out  1  sticky: a byte was dropped.
- done  out  1  sticky: a verdict was written.
- pass  out  1  verdict; valid while done=1.

Behaviour:
- Reset values (async, resetn low): tx=1, busy=0, overflow=0, done=0, pass=0, FIFO empty, FSM in IDLE.
- Reset mid-frame aborts the frame immediately and forces tx=1; FIFO contents are lost.
- Console push: wr_en && wr_addr==CONSOLE_ADDR pushes wr_data[7:0].
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- Status read: rd_addr==CONSOLE_ADDR returns {29'b0, overflow, full, empty}; any other address returns 0.
- Verdict: wr_en && wr_addr==TOHOST_ADDR && done==0 sets done=1 and pass=(wr_data==1). Later verdict writes are ignored.
- A verdict of wr_data==0 is treated as a write and sets done=1, pass=0.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers.
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop into a shift register, set tx<=0, go to START, clear the baud counter.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with tx<=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. A 3-bit counter counts bits; after bit 7 go to STOP with tx<=1.
  - STOP: held CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START directly (back-to-back, no idle gap); otherwise go to IDLE.
- Latency: a push in cycle N to an empty FIFO with the FSM in IDLE gives the start bit on tx from cycle N+2. One frame lasts exactly 10*CLKS_PER_BIT cycles.
- busy = !empty || state!=IDLE.
- Writes to other addresses have no effect.

Decomposition:
- Shared package twitchcore_pkg holds:
  - the CONSOLE_ADDR and TOHOST_ADDR defaults;
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - the status bit index constants.
- One sub-module, byte_fifo: a parameterized synchronous FIFO with push, pop, din, dout, full and empty. uart_console instantiates it alongside the TX FSM.

Test Plan:
- Reset check: hold resetn=0 for 3 cycles, then release -> tx=1, busy=0, done=0, rd_data at CONSOLE_ADDR = 32'h1 (empty).
- Single byte, CLKS_PER_BIT=4: write 0x4F to CONSOLE_ADDR at cycle N -> tx=0 during cycles N+2..N+5, then bits 1,1,1,1,0,0,1,0 (4 cycles each), stop bit=1, busy falls at N+42.
- Back-to-back: write "OK\n" (0x4F, 0x4B, 0x0A) in 3 consecutive cycles -> three contiguous frames with no idle gap, decoded in order, 120 cycles total at CLKS_PER_BIT=4.
- Overflow, FIFO_DEPTH=8: write 10 bytes in 10 consecutive cycles -> the byte in flight plus 8 queued are transmitted; the 10th byte is dropped; overflow=1 and status bit2=1.
- Full + pop: with the FIFO full, write in the exact cycle the FSM pops at the end of STOP -> byte accepted, overflow stays 0.
- Verdict and mid-frame reset:
  - write 1 to TOHOST_ADDR -> done=1, pass=1;
  - a later write of 3 is ignored;
  - after a new reset, write 3 -> done=1, pass=0;
  - assert resetn=0 mid DATA -> tx=1 in the same cycle, FIFO empty.
